rgb_line_framer: RTL and testbench
==================================

// Module: rgb_line_framer
// PURPOSE
//  Downstream of the 32->24 gearbox, in its output clock domain. Takes the unthrottled 24-bit RGB pixel stream
//  (data/last/en) and buffers it in a small FIFO. Emits fixed-length lines (LINE_PIX pixels) on a valid/ready
//  master interface with start-of-line/end-of-line markers. Flags short lines, long lines and buffer overflow.
// PARAMETERS
//  DATA_W      24     pixel width (bits)
//  LINE_PIX    1920   pixels per output line (>=2)
//  CNT_W       12     pixel/line counter width; 2**CNT_W > LINE_PIX
//  FIFO_DEPTH  16     pixel buffer depth, power of 2
//  PAD_VALUE   24'h0  pixel value used for padding (PIX_PAD_EN only)
// PORTS
//  clk_in        input   1       clock (gearbox output clock)
//  reset         input   1       asynchronous, active-low reset (0 = reset)
//  data_in       input   DATA_W  pixel in; no backpressure
//  data_in_last  input   1       qualifies data_in as last pixel of source line
//  data_en       input   1       data_in valid this cycle
//  m_data        output  DATA_W  pixel out
//  m_valid       output  1       m_data valid
//  m_ready       input   1       consumer accepts when m_valid&m_ready
//  m_sol         output  1       first pixel of line (with m_valid)
//  m_eol         output  1       last pixel of line (with m_valid)
//  line_cnt      output  CNT_W   completed lines, wraps at 2**CNT_W
//  err_short     output  1       1-cycle pulse: source line < LINE_PIX pixels
//  err_long      output  1       1-cycle pulse: source line > LINE_PIX pixels
//  overflow      output  1       sticky: pixel lost to full FIFO; cleared only by reset
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, FIFO empty, counters 0, state SOL.
//  - FIFO word = {last,data}. Write on data_en & !full. data_en & full: word dropped, overflow<=1 next edge.
//  - Simultaneous push and pop when full is legal; the push succeeds.
//  - FIFO is show-ahead. A word written at edge N may drive m_valid from N+1 (1-cycle min latency).
//  - Transfer happens on m_valid&m_ready. While m_valid&!m_ready, m_data/m_sol/m_eol are held stable.
//  - pix_cnt counts accepted pixels in the current line: 0..LINE_PIX-1.
//  - FSM states:
//    SOL:  waiting for first pixel. m_sol=1 with it. pix_cnt<=1 on accept (ACTIVE), or SOL if the pixel is also eol.
//    ACTIVE: pass pixels.
//      - Popped word last & pix_cnt<LINE_PIX-1: short line. m_eol=1, err_short pulses on accept, -> SOL.
//      - pix_cnt==LINE_PIX-1 & last: normal end. m_eol=1 -> SOL.
//      - pix_cnt==LINE_PIX-1 & !last: forced end. m_eol=1, err_long pulses on accept -> DROP.
//    DROP: pop FIFO every cycle with m_valid=0 until a word with last is popped -> SOL.
//    PAD (PIX_PAD_EN only): m_valid=1, m_data=PAD_VALUE, no pop. m_eol at pix_cnt==LINE_PIX-1 -> SOL.
//  - line_cnt increments on every accepted m_eol.
//  - Error pulses are aligned to the accepting edge +1 (registered).
//  - Empty FIFO in ACTIVE: m_valid=0, state held.
//  - Reset mid-line: partial line discarded; the next pixel after release gets m_sol.
// CONFIGURATION
//  PIX_PAD_EN defined:
//    - A short line's last source pixel is passed without m_eol, then PAD pixels are emitted up to LINE_PIX total.
//    - m_eol sits on the final pad pixel. err_short still pulses.
//  PIX_PAD_EN undefined:
//    - A short line terminates early with m_eol on the last source pixel. PAD state is not built.
// STRUCTURE
//  - Package rgb_stream_pkg: pixel typedef (DATA_W), FIFO word typedef {last,pixel}, framer state enum
//    {SOL,ACTIVE,DROP,PAD}.
//  - Sub-module rgb_sync_fifo: single-clock show-ahead FIFO, ports wr_en/din/full/rd_en/dout/empty.
//  - Top holds the FSM, counters and flags.
// TESTING (LINE_PIX=8, FIFO_DEPTH=16, m_ready=1 unless stated)
//  1. 8 pixels 0x000001..0x000008, last on 8th -> 8 outputs in order, sol on 0x000001, eol on 0x000008,
//     no errors, line_cnt=1.
//  2. 3 pixels, last on 3rd -> eol on 3rd, err_short one pulse, line_cnt=1.
//     With PIX_PAD_EN: 3 pixels + 5 x 0x000000, eol on 8th.
//  3. 10 pixels, last on 10th -> eol on 8th, err_long pulse, pixels 9-10 never valid.
//     Next line starts with sol on its first pixel.
//  4. m_ready=0, 20 consecutive data_en pixels -> overflow=1 from pixel 17.
//     Then m_ready=1 -> exactly first 16 pixels emitted in order.
//  5. Drive reset=0 after 4 pixels of a line, release, send 8 -> outputs 0 during reset;
//     new line sol on first post-reset pixel, line_cnt=1.
//  6. m_ready random 50% -> m_data held while valid&!ready, no pixel lost or duplicated, sol/eol per test 1.

Source files
------------

// File: rtl/rgb_stream_pkg.sv
// rgb_stream_pkg
//   Shared types for the RGB line framer: pixel type, FIFO word {last,pixel}
//   and the framer state encoding.
package rgb_stream_pkg;

  localparam int PIX_W = 24;

  typedef logic [PIX_W-1:0] pixel_t;

  typedef struct packed {
    logic   last;
    pixel_t pix;
  } fifo_word_t;

  typedef enum logic [1:0] {
    ST_SOL    = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DROP   = 2'd2,
    ST_PAD    = 2'd3
  } framer_state_t;

endpackage

// File: rtl/rgb_sync_fifo.sv
// rgb_sync_fifo
//   Single-clock show-ahead FIFO. dout always presents the oldest word while
//   empty is low. A push while full succeeds only if a pop happens on the
//   same edge.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   wr_en, din, full  write side
//   rd_en, dout, empty read side (rd_en pops the word shown on dout)
module rgb_sync_fifo
  import rgb_stream_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       wr_en,
  input  fifo_word_t din,
  output logic       full,
  input  logic       rd_en,
  output fifo_word_t dout,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  fifo_word_t     mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q;
  logic [AW:0]    rd_ptr_q;
  logic           do_wr_s;
  logic           do_rd_s;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_rd_s = rd_en & ~empty;
  assign do_wr_s = wr_en & (~full | do_rd_s);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (do_wr_s) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (do_rd_s) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage array, no reset needed (guarded by pointers).
  always_ff @(posedge clk) begin
    if (do_wr_s) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/rgb_line_framer.sv
// rgb_line_framer
//   Buffers an unthrottled RGB pixel stream and emits fixed-length lines of
//   LINE_PIX pixels on a valid/ready interface with SOL/EOL markers.
//   Flags short lines, long lines (excess pixels dropped) and FIFO overflow.
//   Optional build macro PIX_PAD_EN: short lines are padded with PAD_VALUE
//   up to LINE_PIX pixels instead of ending early.
// Ports:
//   clk_in, reset                       clock, async active-low reset
//   data_in, data_in_last, data_en      source pixel stream (no backpressure)
//   m_data, m_valid, m_ready            output stream handshake
//   m_sol, m_eol                        line markers qualified by m_valid
//   line_cnt                            completed lines (wrapping)
//   err_short, err_long                 one-cycle error pulses
//   overflow                            sticky, pixel lost to full FIFO
module rgb_line_framer
  import rgb_stream_pkg::*;
#(
  parameter int                 DATA_W     = PIX_W,
  parameter int                 LINE_PIX   = 1920,
  parameter int                 CNT_W      = 12,
  parameter int                 FIFO_DEPTH = 16,
  parameter logic [DATA_W-1:0]  PAD_VALUE  = {DATA_W{1'b0}}
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_last,
  input  logic              data_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              m_sol,
  output logic              m_eol,
  output logic [CNT_W-1:0]  line_cnt,
  output logic              err_short,
  output logic              err_long,
  output logic              overflow
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LINE_PIX - 1);

  logic [1:0]      rst_sync_q;
  logic            rst_n_s;
  framer_state_t   state_q, state_d;
  logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
  logic            err_short_q, err_long_q, ovf_q;
  fifo_word_t      head_s;
  fifo_word_t      wr_word_s;
  logic            empty_s, full_s, pop_s;
  logic            valid_s, sol_s, eol_s, short_s, long_s, accept_s;
  logic [DATA_W-1:0] data_s;
  framer_state_t   nxt_state_s;
  logic [CNT_W-1:0] nxt_cnt_s;

  // Reset: asserted asynchronously, released on the clock.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_s = rst_sync_q[1];

  assign wr_word_s = '{last: data_in_last, pix: data_in};

  rgb_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk_in),
    .rst_n (rst_n_s),
    .wr_en (data_en),
    .din   (wr_word_s),
    .full  (full_s),
    .rd_en (pop_s),
    .dout  (head_s),
    .empty (empty_s)
  );

  // Framer next-state, handshake and marker decode.
  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    pop_s       = 1'b0;
    valid_s     = 1'b0;
    sol_s       = 1'b0;
    eol_s       = 1'b0;
    short_s     = 1'b0;
    long_s      = 1'b0;
    data_s      = head_s.pix;
    nxt_state_s = state_q;
    nxt_cnt_s   = pix_cnt_q;
    case (state_q)
      ST_SOL, ST_ACTIVE: begin
        valid_s = ~empty_s;
        sol_s   = (state_q == ST_SOL);
        if ((state_q == ST_ACTIVE) && (pix_cnt_q == LAST_IDX)) begin
          eol_s       = 1'b1;
          long_s      = ~head_s.last;
          nxt_state_s = head_s.last ? ST_SOL : ST_DROP;
          nxt_cnt_s   = {CNT_W{1'b0}};
        end else if (head_s.last) begin
          short_s = 1'b1;
`ifdef PIX_PAD_EN
          eol_s       = 1'b0;
          nxt_state_s = ST_PAD;
          nxt_cnt_s   = pix_cnt_q + CNT_W'(1);
`else
          eol_s       = 1'b1;
          nxt_state_s = ST_SOL;
          nxt_cnt_s   = {CNT_W{1'b0}};
`endif
        end else begin
          nxt_state_s = ST_ACTIVE;
          nxt_cnt_s   = pix_cnt_q + CNT_W'(1);
        end
        if (valid_s && m_ready) begin
          pop_s     = 1'b1;
          state_d   = nxt_state_s;
          pix_cnt_d = nxt_cnt_s;
        end else begin
          state_d   = state_q;
          pix_cnt_d = pix_cnt_q;
        end
      end
      ST_DROP: begin
        // Discard the tail of an over-long source line; output is idle.
        data_s = PAD_VALUE;
        pop_s  = ~empty_s;
        if (!empty_s && head_s.last) state_d = ST_SOL;
        else                         state_d = ST_DROP;
      end
`ifdef PIX_PAD_EN
      ST_PAD: begin
        valid_s = 1'b1;
        data_s  = PAD_VALUE;
        eol_s   = (pix_cnt_q == LAST_IDX);
        if (m_ready) begin
          if (eol_s) begin
            state_d   = ST_SOL;
            pix_cnt_d = {CNT_W{1'b0}};
          end else begin
            pix_cnt_d = pix_cnt_q + CNT_W'(1);
          end
        end else begin
          pix_cnt_d = pix_cnt_q;
        end
      end
`endif
      default: begin
        state_d   = ST_SOL;
        pix_cnt_d = {CNT_W{1'b0}};
      end
    endcase
    accept_s = valid_s & m_ready;
    if (accept_s && eol_s) line_cnt_d = line_cnt_q + CNT_W'(1);
    else                   line_cnt_d = line_cnt_q;
  end

  // State, counters and flag registers.
  always_ff @(posedge clk_in or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q     <= ST_SOL;
      pix_cnt_q   <= {CNT_W{1'b0}};
      line_cnt_q  <= {CNT_W{1'b0}};
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      err_short_q <= accept_s & short_s;
      err_long_q  <= accept_s & long_s;
      // A push into a full FIFO is lost unless a pop frees the slot this edge.
      ovf_q       <= ovf_q | (data_en & full_s & ~pop_s);
    end
  end

  // Markers and data are forced to zero whenever nothing is offered.
  assign m_valid   = valid_s;
  assign m_data    = valid_s ? data_s : {DATA_W{1'b0}};
  assign m_sol     = valid_s & sol_s;
  assign m_eol     = valid_s & eol_s;
  assign line_cnt  = line_cnt_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_rgb_line_framer.sv
module tb_rgb_line_framer;

  logic        clk_in = 1'b0;
  logic        reset;
  logic [23:0] data_in;
  logic        data_in_last;
  logic        data_en;
  logic [23:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic        m_sol;
  logic        m_eol;
  logic [11:0] line_cnt;
  logic        err_short;
  logic        err_long;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;
  int es_cnt = 0;
  int el_cnt = 0;
  int hold_viol = 0;
  logic prev_stall = 1'b0;
  logic [25:0] prev_w = 26'd0;
  logic rand_en = 1'b0;
  logic [25:0] outq[$];

  rgb_line_framer #(.LINE_PIX(8), .CNT_W(12), .FIFO_DEPTH(16)) dut (
    .clk_in(clk_in), .reset(reset), .data_in(data_in), .data_in_last(data_in_last),
    .data_en(data_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_sol(m_sol), .m_eol(m_eol), .line_cnt(line_cnt), .err_short(err_short),
    .err_long(err_long), .overflow(overflow)
  );

  always #5 clk_in = ~clk_in;

  // Monitor: transfers, error pulses and output stability while stalled.
  always @(negedge clk_in) begin
    if (m_valid && m_ready) outq.push_back({m_data, m_sol, m_eol});
    if (err_short) es_cnt <= es_cnt + 1;
    if (err_long)  el_cnt <= el_cnt + 1;
    if (prev_stall && (!m_valid || ({m_data, m_sol, m_eol} != prev_w)))
      hold_viol <= hold_viol + 1;
    prev_stall <= m_valid & ~m_ready;
    prev_w     <= {m_data, m_sol, m_eol};
  end

  // Random backpressure when enabled.
  always @(posedge clk_in) begin
    if (rand_en) begin
      #1 m_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [23:0] d, input logic last);
    @(posedge clk_in); #1;
    data_in = d; data_in_last = last; data_en = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk_in); #1;
      data_en = 1'b0; data_in_last = 1'b0;
    end
  endtask

  task automatic wait_out(input string tag, input int n, input int budget);
    int c;
    c = 0;
    while (outq.size() < n && c < budget) begin
      @(negedge clk_in);
      c++;
    end
    repeat (4) @(negedge clk_in);
    chk(tag, outq.size(), n);
  endtask

  task automatic exp_pix(input string tag, input int i, input logic [23:0] d,
                         input logic s, input logic e);
    logic [25:0] w;
    w = (i < outq.size()) ? outq[i] : 26'h3ffffff;
    chk(tag, {6'd0, w}, {6'd0, d, s, e});
  endtask

  initial begin
    int es0, el0, hv0;
    reset = 1'b0; data_in = 24'd0; data_in_last = 1'b0; data_en = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("rst_valid", m_valid, 1'b0);
    chk("rst_sol", m_sol, 1'b0);
    chk("rst_eol", m_eol, 1'b0);
    chk("rst_data", m_data, 24'd0);
    chk("rst_line_cnt", line_cnt, 12'd0);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_errs", {err_short, err_long}, 2'b00);
    @(posedge clk_in); #1 reset = 1'b1;
    idle(3);

    // 1: exact-length line
    outq.delete(); es0 = es_cnt; el0 = el_cnt;
    for (int i = 1; i <= 8; i++) send(24'(i), i == 8);
    idle(1);
    wait_out("t1_count", 8, 50);
    for (int i = 0; i < 8; i++) exp_pix("t1_pix", i, 24'(i + 1), i == 0, i == 7);
    chk("t1_err_short", es_cnt - es0, 0);
    chk("t1_err_long", el_cnt - el0, 0);
    chk("t1_line_cnt", line_cnt, 12'd1);

    // 2: short line
    outq.delete(); es0 = es_cnt;
    for (int i = 1; i <= 3; i++) send(24'h10 + 24'(i), i == 3);
    idle(1);
`ifdef PIX_PAD_EN
    wait_out("t2_count", 8, 50);
    for (int i = 0; i < 3; i++) exp_pix("t2_pix", i, 24'h11 + 24'(i), i == 0, 1'b0);
    for (int i = 3; i < 8; i++) exp_pix("t2_pad", i, 24'h0, 1'b0, i == 7);
`else
    wait_out("t2_count", 3, 50);
    for (int i = 0; i < 3; i++) exp_pix("t2_pix", i, 24'h11 + 24'(i), i == 0, i == 2);
`endif
    chk("t2_err_short", es_cnt - es0, 1);
    chk("t2_line_cnt", line_cnt, 12'd2);

    // 3: long line, then a normal line
    outq.delete(); el0 = el_cnt; es0 = es_cnt;
    for (int i = 1; i <= 10; i++) send(24'h20 + 24'(i), i == 10);
    for (int i = 1; i <= 8; i++) send(24'h30 + 24'(i), i == 8);
    idle(1);
    wait_out("t3_count", 16, 80);
    for (int i = 0; i < 8; i++) exp_pix("t3_long", i, 24'h21 + 24'(i), i == 0, i == 7);
    for (int i = 0; i < 8; i++) exp_pix("t3_next", i + 8, 24'h31 + 24'(i), i == 0, i == 7);
    chk("t3_err_long", el_cnt - el0, 1);
    chk("t3_err_short", es_cnt - es0, 0);
    chk("t3_line_cnt", line_cnt, 12'd4);

    // 4: overflow under full backpressure
    outq.delete();
    @(posedge clk_in); #1 m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send(24'h40 + 24'(i), (i % 8) == 0);
    idle(2);
    @(negedge clk_in);
    chk("t4_no_ovf_at_16", overflow, 1'b0);
    for (int i = 17; i <= 20; i++) send(24'h40 + 24'(i), 1'b0);
    idle(2);
    @(negedge clk_in);
    chk("t4_ovf", overflow, 1'b1);
    chk("t4_nothing_out", outq.size(), 0);
    @(posedge clk_in); #1 m_ready = 1'b1;
    wait_out("t4_count", 16, 80);
    for (int i = 0; i < 16; i++)
      exp_pix("t4_pix", i, 24'h41 + 24'(i), (i % 8) == 0, (i % 8) == 7);
    chk("t4_line_cnt", line_cnt, 12'd6);
    chk("t4_ovf_sticky", overflow, 1'b1);

    // 5: reset in the middle of a line
    @(posedge clk_in); #1 m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(24'h60 + 24'(i), 1'b0);
    idle(1);
    @(posedge clk_in); #1 reset = 1'b0; m_ready = 1'b1;
    repeat (2) @(negedge clk_in);
    chk("t5_rst_valid", m_valid, 1'b0);
    chk("t5_rst_data", m_data, 24'd0);
    chk("t5_rst_sol", m_sol, 1'b0);
    chk("t5_rst_line_cnt", line_cnt, 12'd0);
    chk("t5_rst_ovf", overflow, 1'b0);
    @(posedge clk_in); #1 reset = 1'b1;
    idle(3);
    outq.delete();
    for (int i = 1; i <= 8; i++) send(24'h70 + 24'(i), i == 8);
    idle(1);
    wait_out("t5_count", 8, 50);
    for (int i = 0; i < 8; i++) exp_pix("t5_pix", i, 24'h71 + 24'(i), i == 0, i == 7);
    chk("t5_line_cnt", line_cnt, 12'd1);

    // 6: random backpressure
    outq.delete(); hv0 = hold_viol;
    rand_en = 1'b1;
    for (int i = 1; i <= 8; i++) send(24'h80 + 24'(i), i == 8);
    for (int i = 1; i <= 8; i++) send(24'h90 + 24'(i), i == 8);
    idle(1);
    wait_out("t6_count", 16, 400);
    rand_en = 1'b0;
    @(posedge clk_in); #2 m_ready = 1'b1;
    for (int i = 0; i < 8; i++) exp_pix("t6_l1", i, 24'h81 + 24'(i), i == 0, i == 7);
    for (int i = 0; i < 8; i++) exp_pix("t6_l2", i + 8, 24'h91 + 24'(i), i == 0, i == 7);
    chk("t6_hold", hold_viol - hv0, 0);
    chk("t6_line_cnt", line_cnt, 12'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
